// File: rtl/load_store_unit.sv
// Data-bus master for LOAD/STORE: runs one req/ack transaction per memory op, stalls the
// pipeline until it completes, and returns the sign/zero-extended load result.
module load_store_unit #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_bus_read,
  input  logic        cs_bus_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        fault,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byte_en,
  output logic        bus_we,
  output logic        bus_req,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int unsigned    CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_timed_out;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic [31:0]   r_load_data;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic [3:0]    r_byte_en;
  logic          r_we;

  logic          w_op;
  logic          w_legal_f3;
  logic          w_misaligned;
  logic          w_invalid;
  logic          w_launch;
  logic [3:0]    w_byte_en;
  logic [31:0]   w_wdata;
  logic [7:0]    w_rd_byte;
  logic [15:0]   w_rd_half;
  logic [31:0]   w_load_ext;

  // Request decode: legality, lane enables and lane-replicated store data.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_op         = cs_bus_read | cs_bus_write;
    w_legal_f3   = 1'b0;
    w_misaligned = 1'b0;
    w_byte_en    = 4'b1111;
    w_wdata      = store_data;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal_f3 = 1'b1;
      3'b100, 3'b101:         w_legal_f3 = ~cs_bus_write;
      default:                w_legal_f3 = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00: begin
        w_byte_en = 4'b0001 << addr[1:0];
        w_wdata   = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_misaligned = addr[0];
        w_byte_en    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{store_data[15:0]}};
      end
      2'b10:   w_misaligned = |addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
    w_invalid = (cs_bus_read & cs_bus_write) | ~w_legal_f3 | w_misaligned;
    w_launch  = (r_state == S_IDLE) & w_op & ~w_invalid;
  end

  // Lane selection and extension use the offset and size captured at launch.
  always_comb begin
    w_rd_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_off)
      2'd0:    w_rd_byte = bus_rdata[7:0];
      2'd1:    w_rd_byte = bus_rdata[15:8];
      2'd2:    w_rd_byte = bus_rdata[23:16];
      default: w_rd_byte = bus_rdata[31:24];
    endcase
    case (r_f3)
      3'b000:  w_load_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
      3'b100:  w_load_ext = {24'd0, w_rd_byte};
      3'b001:  w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
      3'b101:  w_load_ext = {16'd0, w_rd_half};
      default: w_load_ext = bus_rdata;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_timed_out <= 1'b0;
      r_f3        <= 3'd0;
      r_off       <= 2'd0;
      r_load_data <= 32'd0;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_byte_en   <= 4'd0;
      r_we        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_wdata <= w_wdata;
            r_byte_en   <= w_byte_en;
            r_we        <= cs_bus_write;
            r_f3        <= funct3;
            r_off       <= addr[1:0];
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          // An ack on the last allowed cycle wins over the timeout.
          if (bus_ack) begin
            if (!r_we) r_load_data <= w_load_ext;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_load_data <= 32'd0;
            r_timed_out <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_timed_out <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall       = w_launch | (r_state == S_REQ);
  assign fault       = ((r_state == S_IDLE) & w_op & w_invalid) | ((r_state == S_DONE) & r_timed_out);
  assign bus_req     = (r_state == S_REQ);
  assign load_data   = r_load_data;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_byte_en = r_byte_en;
  assign bus_we      = r_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts every output each
// cycle, and literal expectations pin the model on the headline cases.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_bus_read, cs_bus_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        stall, fault;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byte_en;
  logic        bus_we, bus_req;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  load_store_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cs_bus_read(cs_bus_read), .cs_bus_write(cs_bus_write),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .load_data(load_data), .stall(stall), .fault(fault),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
    .bus_we(bus_we), .bus_req(bus_req),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the bus-side registers and load result must currently hold.
  logic [31:0] m_load_data = '0, m_addr = '0, m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic        m_we = 1'b0;
  logic        exp_stall = 1'b0, exp_fault = 1'b0, exp_req = 1'b0;
  logic        m_check = 1'b0;
  int          stall_cnt = 0, req_cnt = 0, fault_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_check) begin
      check("stall",       {31'd0, stall},       {31'd0, exp_stall});
      check("fault",       {31'd0, fault},       {31'd0, exp_fault});
      check("bus_req",     {31'd0, bus_req},     {31'd0, exp_req});
      check("load_data",   load_data,            m_load_data);
      check("bus_addr",    bus_addr,             m_addr);
      check("bus_wdata",   bus_wdata,            m_wdata);
      check("bus_byte_en", {28'd0, bus_byte_en}, {28'd0, m_be});
      check("bus_we",      {31'd0, bus_we},      {31'd0, m_we});
    end
    stall_cnt += int'(stall === 1'b1);
    req_cnt   += int'(bus_req === 1'b1);
    fault_cnt += int'(fault === 1'b1);
  end

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a);
    int sz = size_of(f3);
    if (rd && wr) return 1'b0;
    if (wr && f3 > 3'd2) return 1'b0;
    if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    if (int'(a[1:0]) % sz != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    return 4'(((1 << sz) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz = size_of(f3);
    if (sz == 1) return (sd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
    int          sz   = size_of(f3);
    logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    logic [31:0] v    = (rd >> (8 * int'(a[1:0]))) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    cs_bus_read  = 1'b0;
    cs_bus_write = 1'b0;
    exp_stall    = 1'b0;
    exp_fault    = 1'b0;
    exp_req      = 1'b0;
  endtask

  // One instruction: present it, answer with ack after ack_at wait cycles (-1 = never),
  // keep it present through the completion cycle, then withdraw it.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdata, input int ack_at);
    logic valid     = model_legal(rd, wr, f3, a);
    logic timed_out = 1'b0;
    stall_cnt = 0; req_cnt = 0; fault_cnt = 0;
    cs_bus_read = rd; cs_bus_write = wr; funct3 = f3; addr = a; store_data = sd;
    exp_stall = valid; exp_fault = ~valid; exp_req = 1'b0;
    step();
    if (!valid) begin
      set_idle();
      return;
    end
    m_addr  = {a[31:2], 2'b00};
    m_be    = model_be(f3, a);
    m_wdata = model_wdata(f3, sd);
    m_we    = wr;
    for (int n = 0; n < TO; n++) begin
      exp_req = 1'b1; exp_stall = 1'b1; exp_fault = 1'b0;
      bus_ack = (n == ack_at); bus_rdata = rdata;
      step();
      if (n == ack_at) begin
        if (rd) m_load_data = model_ext(f3, a, rdata);
        break;
      end
      if (n == TO - 1) begin
        m_load_data = 32'd0;
        timed_out   = 1'b1;
      end
    end
    bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
    exp_req = 1'b0; exp_stall = 1'b0; exp_fault = timed_out;
    step();
    set_idle();
  endtask

  initial begin
    reset = 1'b1;
    cs_bus_read = 1'b0; cs_bus_write = 1'b0; funct3 = 3'd0; addr = '0; store_data = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    step();
    m_check = 1'b1;
    step();
    check("reset_req",   {31'd0, bus_req}, 32'd0);
    check("reset_be",    {28'd0, bus_byte_en}, 32'd0);
    check("reset_ldata", load_data, 32'd0);
    reset = 1'b0;
    step();

    do_op(1, 0, 3'b010, 32'h104, 0, 32'hDEADBEEF, 0);
    check("lw_data",  load_data, 32'hDEADBEEF);
    check("lw_stall", 32'(stall_cnt), 32'd2);
    check("lw_addr",  bus_addr, 32'h104);

    do_op(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0);
    check("lb_be",   {28'd0, bus_byte_en}, 32'h8);
    check("lb_data", load_data, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 0);
    check("lbu_data", load_data, 32'h00000080);

    do_op(1, 0, 3'b010, 32'h40, 0, 32'h12345678, -1);
    check("to_req",   32'(req_cnt), 32'd4);
    check("to_fault", 32'(fault_cnt), 32'd1);
    check("to_data",  load_data, 32'd0);

    do_op(0, 1, 3'b000, 32'h22, 32'h000000A5, 0, 3);
    check("sb_we",    {31'd0, bus_we}, 32'd1);
    check("sb_be",    {28'd0, bus_byte_en}, 32'h4);
    check("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    check("sb_stall", 32'(stall_cnt), 32'd5);
    check("sb_addr",  bus_addr, 32'h20);

    do_op(1, 0, 3'b001, 32'h101, 0, 32'hFFFFFFFF, 0);
    check("lh_mis_fault", 32'(fault_cnt), 32'd1);
    check("lh_mis_req",   32'(req_cnt), 32'd0);
    check("lh_mis_stall", 32'(stall_cnt), 32'd0);

    do_op(1, 0, 3'b001, 32'h102, 0, 32'h80017FFF, 1);
    check("lh_hi", load_data, 32'hFFFF8001);
    do_op(1, 0, 3'b101, 32'h102, 0, 32'h80017FFF, 0);
    check("lhu_hi", load_data, 32'h00008001);
    do_op(0, 1, 3'b001, 32'h002, 32'h1234ABCD, 0, 2);
    check("sh_wdata", bus_wdata, 32'hABCDABCD);
    check("sh_be",    {28'd0, bus_byte_en}, 32'hC);
    check("sh_ldata_held", load_data, 32'h00008001);
    do_op(0, 1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 0);
    do_op(1, 0, 3'b100, 32'h01, 0, 32'h11223344, 0);
    check("lbu_lane1", load_data, 32'h00000033);

    do_op(1, 1, 3'b010, 32'h0, 0, 0, 0);
    check("rdwr_fault", 32'(fault_cnt), 32'd1);
    do_op(0, 1, 3'b100, 32'h0, 32'h1, 0, 0);
    do_op(1, 0, 3'b010, 32'h2, 0, 0, 0);
    do_op(1, 0, 3'b011, 32'h0, 0, 0, 0);
    do_op(1, 0, 3'b101, 32'h103, 0, 0, 0);
    check("lhu_mis_req", 32'(req_cnt), 32'd0);

    // Reset during the second REQ cycle of a load with no ack.
    cs_bus_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
    exp_stall = 1'b1; exp_fault = 1'b0; exp_req = 1'b0;
    step();
    m_addr = 32'h200; m_be = 4'hF; m_we = 1'b0; m_wdata = 32'h0000_0000;
    m_wdata = model_wdata(3'b010, store_data);
    exp_req = 1'b1;
    step();
    reset = 1'b1; cs_bus_read = 1'b0;
    step();
    m_load_data = '0; m_addr = '0; m_wdata = '0; m_be = '0; m_we = 1'b0;
    set_idle();
    check("rst_req",   {31'd0, bus_req}, 32'd0);
    check("rst_addr",  bus_addr, 32'd0);
    check("rst_ldata", load_data, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    step();
    do_op(1, 0, 3'b010, 32'h8, 0, 32'h0BADF00D, 0);
    check("post_rst_lw", load_data, 32'h0BADF00D);

    m_check = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
